seg7_scan_ctrl: RTL

- Time-multiplexed scan controller for the 4-digit 7-segment display.
- Holds a 4-digit BCD frame and steps the 2-bit digit select through 0..3.
- The select drives the one-hot digit enable in the order 00→D1, 01→D2, 10→D3, 11→D4.
- Adds anti-ghost blanking between digits, tear-free frame updates, leading-zero suppression and BCD→segment decode.

---
 rtl/seg7_scan_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// It adds per-slot blanking, frame-aligned data updates, leading-zero blanking and BCD decode.
module seg7_scan_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [1:0]  sel,
  output logic [3:0]  digit,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  // With no blanking configured, every slot starts straight in DRIVE.
  localparam state_t SLOT_START = (BLANK_CYC == 0) ? DRIVE : BLANK;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      active_data, pend_data;
  logic [3:0]       active_dp, pend_dp;
  logic             pend_flag;

  logic [3:0] cur_bcd;
  logic       cur_dp;
  logic       cur_lz;
  logic [6:0] drive_seg;
  logic       boundary;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    cur_bcd = active_data[3:0];
    cur_dp  = active_dp[0];
    cur_lz  = 1'b0;
    case (sel)
      2'd0: begin
        cur_bcd = active_data[15:12];
        cur_dp  = active_dp[3];
        cur_lz  = (active_data[15:12] == 4'd0);
      end
      2'd1: begin
        cur_bcd = active_data[11:8];
        cur_dp  = active_dp[2];
        cur_lz  = (active_data[15:8] == 8'd0);
      end
      2'd2: begin
        cur_bcd = active_data[7:4];
        cur_dp  = active_dp[1];
        cur_lz  = (active_data[15:4] == 12'd0);
      end
      default: begin
        cur_bcd = active_data[3:0];
        cur_dp  = active_dp[0];
        cur_lz  = 1'b0;
      end
    endcase
    drive_seg = (lz_en && cur_lz) ? 7'd0 : bcd_to_seg(cur_bcd);
  end

  assign boundary = en && (state == DRIVE) && (sel == 2'd3) && (cnt == SLOT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the frame buffers are small registers, so they are reset along with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= 2'd0;
      digit       <= 4'd0;
      seg         <= 7'd0;
      dp          <= 1'b0;
      frame       <= 1'b0;
      active_data <= 16'd0;
      active_dp   <= 4'd0;
      pend_data   <= 16'd0;
      pend_dp     <= 4'd0;
      pend_flag   <= 1'b0;
    end else begin
      digit <= 4'd0;
      seg   <= 7'd0;
      dp    <= 1'b0;
      frame <= 1'b0;

      // Frame data only changes on the wrap edge, so a frame is never torn.
      if (boundary) begin
        frame     <= 1'b1;
        pend_flag <= 1'b0;
        if (load) begin
          active_data <= data;
          active_dp   <= dp_in;
        end else if (pend_flag) begin
          active_data <= pend_data;
          active_dp   <= pend_dp;
        end
      end else if (load) begin
        if (state == IDLE) begin
          active_data <= data;
          active_dp   <= dp_in;
        end else begin
          pend_data <= data;
          pend_dp   <= dp_in;
          pend_flag <= 1'b1;
        end
      end

      if (!en) begin
        state <= IDLE;
        sel   <= 2'd0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= SLOT_START;
            sel   <= 2'd0;
            cnt   <= '0;
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_LAST) state <= DRIVE;
          end
          DRIVE: begin
            digit <= 4'b1000 >> sel;
            seg   <= drive_seg;
            dp    <= cur_dp;
            if (cnt == SLOT_LAST) begin
              cnt   <= '0;
              sel   <= sel + 2'd1;
              state <= SLOT_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
